// File: rtl/temp_monitor_if.sv
// Bundle between the keypad digit-entry stage (master) and temp_monitor (slave):
// BCD digits plus request flag in, binary reading, statistics and alarm status out.
interface temp_monitor_if;
    logic        new_number;
    logic [3:0]  temp_value_ones;
    logic [3:0]  temp_value_tens;
    logic [3:0]  temp_value_huns;
    logic [9:0]  temp_bin;
    logic        temp_valid;
    logic [10:0] delta;
    logic [9:0]  temp_min;
    logic [9:0]  temp_max;
    logic [1:0]  alarm_state;
    logic        alarm_high;
    logic        alarm_low;
    logic        busy;

    modport master (
        output new_number, temp_value_ones, temp_value_tens, temp_value_huns,
        input  temp_bin, temp_valid, delta, temp_min, temp_max,
               alarm_state, alarm_high, alarm_low, busy
    );

    modport slave (
        input  new_number, temp_value_ones, temp_value_tens, temp_value_huns,
        output temp_bin, temp_valid, delta, temp_min, temp_max,
               alarm_state, alarm_high, alarm_low, busy
    );
endinterface

// File: rtl/temp_monitor.sv
// Converts each completed BCD temperature entry to binary, tracks delta/min/max
// and runs a high/low alarm with hysteresis.
//
// state   | meaning
// --------+-------------------------------------------------
// IDLE    | waiting for a new_number rise or a pending request
// CAP     | latch (clamped) digits, clear accumulator
// ACC_H   | acc = huns*100
// ACC_T   | acc += tens*10
// ACC_O   | acc += ones
// EVAL    | update reading, delta, min/max, alarm; pulse temp_valid
module temp_monitor #(
    parameter int unsigned HIGH_SET = 100,
    parameter int unsigned HIGH_CLR = 95,
    parameter int unsigned LOW_SET  = 32,
    parameter int unsigned LOW_CLR  = 37
) (
    input logic           clk_i,
    input logic           rst_i,
    temp_monitor_if.slave bus
);
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CAP   = 3'd1;
    localparam logic [2:0] ST_ACC_H = 3'd2;
    localparam logic [2:0] ST_ACC_T = 3'd3;
    localparam logic [2:0] ST_ACC_O = 3'd4;
    localparam logic [2:0] ST_EVAL  = 3'd5;

    localparam logic [1:0] AL_NORMAL = 2'd0;
    localparam logic [1:0] AL_HIGH   = 2'd1;
    localparam logic [1:0] AL_LOW    = 2'd2;

    localparam logic [9:0] HIGH_SET_C = 10'(HIGH_SET);
    localparam logic [9:0] HIGH_CLR_C = 10'(HIGH_CLR);
    localparam logic [9:0] LOW_SET_C  = 10'(LOW_SET);
    localparam logic [9:0] LOW_CLR_C  = 10'(LOW_CLR);

    logic        s1_q, s2_q, s3_q;
    logic        rise;
    logic [2:0]  state_q, state_d;
    logic        pending_q, pending_d;
    logic [3:0]  huns_q, huns_d;
    logic [3:0]  tens_q, tens_d;
    logic [3:0]  ones_q, ones_d;
    logic [9:0]  acc_q, acc_d;
    logic        prev_valid_q, prev_valid_d;
    logic [9:0]  temp_bin_q, temp_bin_d;
    logic        temp_valid_q, temp_valid_d;
    logic [10:0] delta_q, delta_d;
    logic [9:0]  temp_min_q, temp_min_d;
    logic [9:0]  temp_max_q, temp_max_d;
    logic [1:0]  alarm_q, alarm_d;

    function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    assign rise = s2_q & ~s3_q;

    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        huns_d       = huns_q;
        tens_d       = tens_q;
        ones_d       = ones_q;
        acc_d        = acc_q;
        prev_valid_d = prev_valid_q;
        temp_bin_d   = temp_bin_q;
        temp_valid_d = 1'b0;
        delta_d      = delta_q;
        temp_min_d   = temp_min_q;
        temp_max_d   = temp_max_q;
        alarm_d      = alarm_q;

        case (state_q)
            ST_IDLE: begin
                if (rise || pending_q) begin
                    state_d   = ST_CAP;
                    pending_d = 1'b0;
                end
            end
            ST_CAP: begin
                huns_d  = clamp_bcd(bus.temp_value_huns);
                tens_d  = clamp_bcd(bus.temp_value_tens);
                ones_d  = clamp_bcd(bus.temp_value_ones);
                acc_d   = '0;
                state_d = ST_ACC_H;
            end
            ST_ACC_H: begin
                acc_d   = 10'(huns_q) * 10'd100;
                state_d = ST_ACC_T;
            end
            ST_ACC_T: begin
                acc_d   = acc_q + 10'(tens_q) * 10'd10;
                state_d = ST_ACC_O;
            end
            ST_ACC_O: begin
                acc_d   = acc_q + 10'(ones_q);
                state_d = ST_EVAL;
            end
            ST_EVAL: begin
                temp_bin_d   = acc_q;
                temp_valid_d = 1'b1;
                prev_valid_d = 1'b1;
                if (!prev_valid_q) begin
                    delta_d    = '0;
                    temp_min_d = acc_q;
                    temp_max_d = acc_q;
                end else begin
                    delta_d = {1'b0, acc_q} - {1'b0, temp_bin_q};
                    if (acc_q < temp_min_q) temp_min_d = acc_q;
                    if (acc_q > temp_max_q) temp_max_d = acc_q;
                end
                case (alarm_q)
                    AL_HIGH: begin
                        if (acc_q <= LOW_SET_C)      alarm_d = AL_LOW;
                        else if (acc_q < HIGH_CLR_C) alarm_d = AL_NORMAL;
                    end
                    AL_LOW: begin
                        if (acc_q >= HIGH_SET_C)     alarm_d = AL_HIGH;
                        else if (acc_q > LOW_CLR_C)  alarm_d = AL_NORMAL;
                    end
                    default: begin
                        if (acc_q >= HIGH_SET_C)     alarm_d = AL_HIGH;
                        else if (acc_q <= LOW_SET_C) alarm_d = AL_LOW;
                        else                         alarm_d = AL_NORMAL;
                    end
                endcase
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // One-deep queue: a rise during a conversion is remembered, extras are lost.
        if (rise && (state_q != ST_IDLE)) pending_d = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            s3_q         <= 1'b0;
            state_q      <= ST_IDLE;
            pending_q    <= 1'b0;
            huns_q       <= '0;
            tens_q       <= '0;
            ones_q       <= '0;
            acc_q        <= '0;
            prev_valid_q <= 1'b0;
            temp_bin_q   <= '0;
            temp_valid_q <= 1'b0;
            delta_q      <= '0;
            temp_min_q   <= '0;
            temp_max_q   <= '0;
            alarm_q      <= AL_NORMAL;
        end else begin
            s1_q         <= bus.new_number;
            s2_q         <= s1_q;
            s3_q         <= s2_q;
            state_q      <= state_d;
            pending_q    <= pending_d;
            huns_q       <= huns_d;
            tens_q       <= tens_d;
            ones_q       <= ones_d;
            acc_q        <= acc_d;
            prev_valid_q <= prev_valid_d;
            temp_bin_q   <= temp_bin_d;
            temp_valid_q <= temp_valid_d;
            delta_q      <= delta_d;
            temp_min_q   <= temp_min_d;
            temp_max_q   <= temp_max_d;
            alarm_q      <= alarm_d;
        end
    end

    assign bus.temp_bin    = temp_bin_q;
    assign bus.temp_valid  = temp_valid_q;
    assign bus.delta       = delta_q;
    assign bus.temp_min    = temp_min_q;
    assign bus.temp_max    = temp_max_q;
    assign bus.alarm_state = alarm_q;
    assign bus.alarm_high  = (alarm_q == AL_HIGH);
    assign bus.alarm_low   = (alarm_q == AL_LOW);
    assign bus.busy        = (state_q != ST_IDLE);
endmodule
